// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake bundle: request, operands, annul, result and stall.
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        DivStallE;

  modport master (
    output start, signed_div, a, b, annul,
    input  result, ready, DivStallE
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output result, ready, DivStallE
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for div/divu: 32 BUSY cycles, one-cycle divide-by-zero path,
// sign fix-up on completion, and a combinational stall request into the hazard unit.
module div_unit (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StZero, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sd_q, sd_d;
  logic [63:0] result_q, result_d;

  logic [31:0] in_a_abs;
  logic [31:0] b_abs;
  logic [33:0] rem_sh;
  logic [33:0] diff;
  logic [64:0] step;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // One restoring step on the working register {partial remainder, quotient}.
  always_comb begin
    in_a_abs = (bus.signed_div && bus.a[31]) ? -bus.a : bus.a;
    b_abs    = (sd_q && b_q[31]) ? -b_q : b_q;
    rem_sh   = {work_q[64:32], work_q[31]};
    diff     = rem_sh - {2'b00, b_abs};
    if (diff[33]) begin
      step = {rem_sh[32:0], work_q[30:0], 1'b0};
    end else begin
      step = {diff[32:0], work_q[30:0], 1'b1};
    end
    q_fix = (sd_q && (a_q[31] ^ b_q[31])) ? -step[31:0] : step[31:0];
    r_fix = (sd_q && a_q[31]) ? -step[63:32] : step[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    a_d      = a_q;
    b_d      = b_q;
    sd_d     = sd_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (bus.start && !bus.annul) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sd_d    = bus.signed_div;
          cnt_d   = 5'd0;
          work_d  = {33'd0, in_a_abs};
          state_d = (bus.b == 32'd0) ? StZero : StBusy;
        end
      end
      StBusy: begin
        work_d = step;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = StDone;
          result_d = {r_fix, q_fix};
        end
      end
      StZero: begin
        state_d  = StDone;
        result_d = {a_q, 32'hFFFF_FFFF};
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Flush wins everywhere: abandon the operation and leave the last result in place.
    if (bus.annul) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      work_q   <= 65'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sd_q     <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sd_q     <= sd_d;
      result_q <= result_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.ready     = (state_q == StDone) && !bus.annul;
  // Low in DONE so the stalled instruction advances on the edge that ends it.
  assign bus.DivStallE = resetn && !bus.annul &&
                         (((state_q == StIdle) && bus.start) ||
                          (state_q == StBusy) || (state_q == StZero));

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, a negedge monitor checks them.
module tb_div_unit;

  logic clk;
  logic resetn;
  div_unit_if bus ();

  div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          issue;
    int          base;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks;
  int          failures;
  int          cyc;
  int          stall_total;
  logic [63:0] last_res;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    stall_total = 0;
    last_res = 64'd0;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with MIPS-style divide-by-zero result.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic sd);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sd) begin
      sx = $signed(x);
      sy = $signed(y);
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (resetn && bus.ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got result %h expected no ready", bus.result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
        chk("stall_cycles", 64'(stall_total - mon_e.base), 64'(mon_e.lat));
        chk("stall_in_done", {63'd0, bus.DivStallE}, 64'd0);
        last_res = mon_e.res;
      end
    end
    if (bus.DivStallE) stall_total++;
  end

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic sd);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.a          = ai;
    bus.b          = bi;
    bus.signed_div = sd;
    e.res   = ref_div(ai, bi, sd);
    e.issue = cyc;
    e.base  = stall_total;
    e.lat   = (bi == 32'd0) ? 2 : 33;
    sb.push_back(e);
    // Operand churn after acceptance must not disturb the division.
    @(posedge clk);
    #1;
    bus.a          = $urandom;
    bus.b          = $urandom;
    bus.signed_div = 1'($urandom);
    n = 0;
    while (!bus.ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got no ready after %0d cycles expected ready", n);
      if (sb.size() != 0) void'(sb.pop_back());
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.a          = 32'd0;
    bus.b          = 32'd0;
    bus.annul      = 1'b0;
    resetn         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, bus.ready}, 64'd0);
    chk("reset_stall", {63'd0, bus.DivStallE}, 64'd0);
    chk("reset_result", bus.result, 64'd0);
    bus.start = 1'b0;
    #2 resetn = 1'b1;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(32'h0000_1234, 32'd0, 1'b0);

    // Annul at BUSY counter 10, then an immediate fresh division.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.signed_div = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    bus.start = 1'b0;
    #1 chk("annul_stall", {63'd0, bus.DivStallE}, 64'd0);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    chk("annul_no_ready", {63'd0, bus.ready}, 64'd0);
    chk("annul_result_kept", bus.result, last_res);
    chk("annul_idle", {63'd0, bus.DivStallE}, 64'd0);
    run_op(32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
      run_op(ra, rb, 1'($urandom));
    end

    // Annul beats start in IDLE.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.a = 32'd5;
    bus.b = 32'd1;
    #1 chk("annul_priority_stall", {63'd0, bus.DivStallE}, 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    #1 chk("annul_priority_idle", {63'd0, bus.DivStallE}, 64'd0);

    // Asynchronous reset mid-BUSY, between edges.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = $urandom;
    bus.b = 32'd3;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("async_reset_ready", {63'd0, bus.ready}, 64'd0);
    chk("async_reset_stall", {63'd0, bus.DivStallE}, 64'd0);
    chk("async_reset_result", bus.result, 64'd0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    #2 resetn = 1'b1;
    last_res = 64'd0;
    run_op(32'd100, 32'd7, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: execute-stage div/divu request, level-held by the pipeline while the stall is asserted.
REQ-004 SHALL have port signed_div, input, 1 bit: 1 = div (two's complement), 0 = divu.
REQ-005 SHALL have port a, input, 32 bits: dividend (rs value after forwarding).
REQ-006 SHALL have port b, input, 32 bits: divisor (rt value after forwarding).
REQ-007 SHALL have port annul, input, 1 bit: cancel the in-flight operation (exception/flush).
REQ-008 SHALL have port result, output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL have port ready, output, 1 bit: result valid this cycle.
REQ-010 SHALL have port DivStallE, output, 1 bit: stall request into the hazard unit (freezes F/D/E, bubbles M).

Function
REQ-011 SHALL implement states IDLE, BUSY, ZERO, DONE.
REQ-012 SHALL, in IDLE with start=1 and annul=0, latch a, b, signed_div; go to ZERO if b==0, else BUSY with iteration counter=0.
REQ-013 SHALL perform one restoring radix-2 step per BUSY cycle on |a|, |b| (absolute values when signed_div=1, raw when 0): 32 BUSY cycles, counter 0..31, then DONE.
REQ-014 SHALL hold a 65-bit working register (33-bit partial remainder + 32-bit quotient); subtraction is 33-bit, so no carry is lost for divisor >= 2^31.
REQ-015 SHALL go from ZERO to DONE in one cycle with quotient=32'hFFFFFFFF, remainder=a (latched).
REQ-016 SHALL apply sign correction at BUSY->DONE: quotient negated when signed_div=1 and a[31]^b[31]; remainder negated when signed_div=1 and a[31]=1.
REQ-017 SHALL produce, for signed 0x80000000 / 0xFFFFFFFF, quotient 0x80000000 and remainder 0 (32-bit wrap, no trap).
REQ-018 SHALL assert ready=1 only in DONE (exactly one cycle), then return to IDLE.
REQ-019 SHALL hold result stable from DONE until the next accepted start; ready=0 in all states other than DONE.
REQ-020 SHALL drive DivStallE = (IDLE & start & ~annul) | BUSY | ZERO, combinationally; DivStallE=0 in DONE so the instruction advances on that edge.
REQ-021 SHALL, from start sampled at edge 0, give ready=1 in cycle 33 (b!=0) or cycle 2 (b==0).
REQ-022 SHALL ignore start and operand changes while in BUSY, ZERO or DONE.
REQ-023 SHALL, on annul=1 in any state, go to IDLE next edge, with no ready pulse, result unchanged and DivStallE=0 combinationally in that cycle.
REQ-024 SHALL give annul priority over start when both are asserted in IDLE.

Reset
REQ-025 SHALL, on resetn=0, immediately force state=IDLE, counter=0, working register=0, result=0, ready=0, DivStallE=0 (start ignored while resetn=0).
REQ-026 SHALL, on reset mid-operation, discard the operation; the first start after resetn=1 begins a fresh division.

Verification
REQ-027 SHALL cover unsigned: a=100, b=7, signed_div=0 -> DivStallE high cycles 0..32; ready in cycle 33; result={32'd2, 32'd14}.
REQ-028 SHALL cover signed: a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); a=7, b=-2 -> quotient -3, remainder 1.
REQ-029 SHALL cover edge values: signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}; unsigned 0xFFFFFFFF/0x80000000 -> {0x7FFFFFFF, 1}.
REQ-030 SHALL cover divide by zero: a=0x1234, b=0 -> ready in cycle 2; result={0x00001234, 0xFFFFFFFF}.
REQ-031 SHALL cover annul: annul at BUSY counter=10 -> IDLE next cycle, no ready, result keeps prior value; immediate new start 9/3 -> {0, 3} after 33 cycles.
REQ-032 SHALL cover async reset: resetn low mid-BUSY (between edges) -> ready=0, DivStallE=0, result=0 without a clock edge.
